// File: rtl/class_argmax_pkg.sv
// Shared types for the class argmax block.
// Holds the FSM state encoding and a width helper.
package class_argmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } argmax_state_t;

    // Index width for n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/class_argmax.sv
// Sequential argmax over CLASS_NUM signed class sums.
// Ports: clk, rst_n (async low), adder_done, class_sums[] in;
//        pred_class, max_sum, pred_valid, busy, overrun out.
module class_argmax
    import class_argmax_pkg::*;
#(
    parameter int CLASS_NUM     = 10,
    parameter int WEIGHT_LENGTH = 14,
    parameter int CLASS_IDX_W   = idx_width(CLASS_NUM)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            adder_done,
    input  logic signed [WEIGHT_LENGTH-1:0] class_sums [CLASS_NUM],
    output logic        [CLASS_IDX_W-1:0]   pred_class,
    output logic signed [WEIGHT_LENGTH-1:0] max_sum,
    output logic                            pred_valid,
    output logic                            busy,
    output logic                            overrun
);

    // Counter must also hold the value 1 when CLASS_NUM is 1.
    localparam int              CNT_W = idx_width(CLASS_NUM + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLASS_NUM - 1);

    argmax_state_t                   r_state;
    logic                            r_adder_done_q;
    logic [CNT_W-1:0]                r_cnt;
    logic signed [WEIGHT_LENGTH-1:0] r_sums [CLASS_NUM];
    logic signed [WEIGHT_LENGTH-1:0] r_cur_max;
    logic [CLASS_IDX_W-1:0]          r_cur_idx;
    logic [CLASS_IDX_W-1:0]          r_pred_class;
    logic signed [WEIGHT_LENGTH-1:0] r_max_sum;
    logic                            r_pred_valid;
    logic                            r_busy;
    logic                            r_overrun;

    logic                            w_rise;
    logic signed [WEIGHT_LENGTH-1:0] w_cand;
    logic                            w_greater;
    logic signed [WEIGHT_LENGTH-1:0] w_nxt_max;
    logic [CLASS_IDX_W-1:0]          w_nxt_idx;

    assign w_rise = adder_done & ~r_adder_done_q;

    // Candidate selected by counter; compare-mux avoids an
    // index wider than the array needs.
    always_comb begin
        w_cand = r_sums[0];
        for (int i = 0; i < CLASS_NUM; i++) begin
            if (r_cnt == CNT_W'(i)) w_cand = r_sums[i];
        end
    end

    // Strictly greater keeps the lowest index on ties.
    assign w_greater = (w_cand > r_cur_max);
    assign w_nxt_max = w_greater ? w_cand : r_cur_max;
    assign w_nxt_idx = w_greater ? CLASS_IDX_W'(r_cnt) : r_cur_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_adder_done_q <= 1'b0;
            r_cnt          <= '0;
            r_cur_max      <= '0;
            r_cur_idx      <= '0;
            r_pred_class   <= '0;
            r_max_sum      <= '0;
            r_pred_valid   <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            for (int i = 0; i < CLASS_NUM; i++) r_sums[i] <= '0;
        end else begin
            r_adder_done_q <= adder_done;
            r_pred_valid   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        for (int i = 0; i < CLASS_NUM; i++) begin
                            r_sums[i] <= class_sums[i];
                        end
                        r_cur_max <= class_sums[0];
                        r_cur_idx <= '0;
                        r_cnt     <= CNT_W'(1);
                        r_busy    <= 1'b1;
                        if (CLASS_NUM > 1) begin
                            r_state <= ST_SCAN;
                        end else begin
                            r_state      <= ST_DONE;
                            r_pred_valid <= 1'b1;
                            r_pred_class <= '0;
                            r_max_sum    <= class_sums[0];
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_rise) r_overrun <= 1'b1;
                    r_cur_max <= w_nxt_max;
                    r_cur_idx <= w_nxt_idx;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_state      <= ST_DONE;
                        r_pred_valid <= 1'b1;
                        r_pred_class <= w_nxt_idx;
                        r_max_sum    <= w_nxt_max;
                    end
                end
                ST_DONE: begin
                    // An edge here is dropped, not captured.
                    if (w_rise) r_overrun <= 1'b1;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pred_class = r_pred_class;
    assign max_sum    = r_max_sum;
    assign pred_valid = r_pred_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_class_argmax.sv
// Testbench for class_argmax (CLASS_NUM=4 and CLASS_NUM=1).
// Table vectors, random vectors vs. a model, corner sequences.
module tb_class_argmax;

    typedef logic signed [7:0] s8_t;
    typedef s8_t sv4_t [4];
    typedef struct {
        sv4_t  s;
        int    eidx;
        int    emax;
        string nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              ad4;
    sv4_t              sums4;
    logic [1:0]        pc4;
    logic signed [7:0] ms4;
    logic              pv4, bz4, ov4;

    logic              ad1;
    s8_t               sums1 [1];
    logic [0:0]        pc1;
    logic signed [7:0] ms1;
    logic              pv1, bz1, ov1;

    int n_checks = 0;
    int n_fail   = 0;

    class_argmax #(
        .CLASS_NUM(4), .WEIGHT_LENGTH(8)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .adder_done(ad4),
        .class_sums(sums4), .pred_class(pc4), .max_sum(ms4),
        .pred_valid(pv4), .busy(bz4), .overrun(ov4)
    );

    class_argmax #(
        .CLASS_NUM(1), .WEIGHT_LENGTH(8)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .adder_done(ad1),
        .class_sums(sums1), .pred_class(pc1), .max_sum(ms1),
        .pred_valid(pv1), .busy(bz1), .overrun(ov1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic sv4_t mk4(input int a, b, c, d);
        sv4_t r;
        r[0] = 8'(a);
        r[1] = 8'(b);
        r[2] = 8'(c);
        r[3] = 8'(d);
        return r;
    endfunction

    function automatic vec_t mkv(input int a, b, c, d,
                                 input int ei, em, input string nm);
        vec_t v;
        v.s    = mk4(a, b, c, d);
        v.eidx = ei;
        v.emax = em;
        v.nm   = nm;
        return v;
    endfunction

    // Reference: find the largest value, then the first index holding it.
    function automatic void ref_argmax(input sv4_t s,
                                       output int idx, output int mx);
        mx = int'(s[0]);
        for (int i = 1; i < 4; i++) begin
            if (int'(s[i]) > mx) mx = int'(s[i]);
        end
        idx = -1;
        for (int i = 3; i >= 0; i--) begin
            if (int'(s[i]) == mx) idx = i;
        end
    endfunction

    // Waits for pred_valid; lat counts negedges since the drive edge.
    task automatic wait_pv4(input int start, output int lat);
        lat = -1;
        for (int k = start + 1; k <= start + 12; k++) begin
            @(negedge clk);
            if (pv4) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic count_pv4(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (pv4) cnt++;
        end
    endtask

    task automatic run_vec(input sv4_t s, input int ei, input int em,
                           input string nm);
        int lat;
        @(negedge clk);
        sums4 = s;
        ad4   = 1'b1;
        wait_pv4(0, lat);
        chk({nm, "_lat"}, lat, 4);
        chk({nm, "_idx"}, int'(pc4), ei);
        chk({nm, "_max"}, int'(ms4), em);
        chk({nm, "_busy"}, int'(bz4), 1);
        @(negedge clk);
        ad4 = 1'b0;
        chk({nm, "_pv_off"}, int'(pv4), 0);
        chk({nm, "_hold"}, int'(pc4), ei);
        chk({nm, "_idle"}, int'(bz4), 0);
    endtask

    vec_t vecs [6];

    initial begin
        int lat;
        int cnt;
        int ei;
        int em;
        sv4_t s;

        vecs[0] = mkv(5, -3, 12, 7, 2, 12, "basic");
        vecs[1] = mkv(-8, -2, -2, -100, 1, -2, "signed_tie");
        vecs[2] = mkv(0, 0, 0, 0, 0, 0, "all_zero");
        vecs[3] = mkv(-128, -128, 127, 127, 2, 127, "extremes");
        vecs[4] = mkv(-1, -1, -1, -1, 0, -1, "all_neg");
        vecs[5] = mkv(-128, -128, -128, -127, 3, -127, "last_wins");

        rst_n    = 1'b0;
        ad4      = 1'b0;
        ad1      = 1'b0;
        sums4    = mk4(0, 0, 0, 0);
        sums1[0] = 8'sd0;
        repeat (2) @(negedge clk);
        chk("rst_pv", int'(pv4), 0);
        chk("rst_pc", int'(pc4), 0);
        chk("rst_ms", int'(ms4), 0);
        chk("rst_busy", int'(bz4), 0);
        chk("rst_ovr", int'(ov4), 0);
        rst_n = 1'b1;

        // Single-class instance: result one cycle after capture.
        @(negedge clk);
        sums1[0] = -8'sd5;
        ad1 = 1'b1;
        @(negedge clk);
        chk("n1_pv", int'(pv1), 1);
        chk("n1_idx", int'(pc1), 0);
        chk("n1_max", int'(ms1), -5);
        chk("n1_busy", int'(bz1), 1);
        @(negedge clk);
        chk("n1_pv_off", int'(pv1), 0);
        chk("n1_idle", int'(bz1), 0);
        ad1 = 1'b0;
        @(negedge clk);
        sums1[0] = 8'sd37;
        ad1 = 1'b1;
        @(negedge clk);
        chk("n1b_pv", int'(pv1), 1);
        chk("n1b_max", int'(ms1), 37);
        @(negedge clk);
        ad1 = 1'b0;
        chk("n1_ovr", int'(ov1), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i].s, vecs[i].eidx, vecs[i].emax, vecs[i].nm);
        end

        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i % 3 == 0) s[j] = 8'($urandom_range(0, 3)) - 8'sd2;
                else            s[j] = 8'($urandom_range(0, 255));
            end
            ref_argmax(s, ei, em);
            run_vec(s, ei, em, $sformatf("rnd%0d", i));
        end
        chk("no_overrun", int'(ov4), 0);

        // Inputs change after capture while adder_done stays high.
        @(negedge clk);
        sums4 = mk4(1, 2, 3, 4);
        ad4 = 1'b1;
        @(negedge clk);
        sums4 = mk4(99, 0, 0, 0);
        wait_pv4(1, lat);
        chk("hold_lat", lat, 4);
        chk("hold_idx", int'(pc4), 3);
        chk("hold_max", int'(ms4), 4);
        count_pv4(6, cnt);
        chk("hold_no_retrig", cnt, 0);
        chk("hold_ovr", int'(ov4), 0);
        @(negedge clk);
        ad4 = 1'b0;

        // Re-raise during SCAN: dropped and flagged.
        @(negedge clk);
        sums4 = mk4(5, -3, 12, 7);
        ad4 = 1'b1;
        @(negedge clk);
        ad4 = 1'b0;
        @(negedge clk);
        ad4 = 1'b1;
        wait_pv4(2, lat);
        chk("ovr_lat", lat, 4);
        chk("ovr_idx", int'(pc4), 2);
        chk("ovr_max", int'(ms4), 12);
        count_pv4(8, cnt);
        chk("ovr_no_second", cnt, 0);
        chk("ovr_flag", int'(ov4), 1);
        @(negedge clk);
        ad4 = 1'b0;

        // Reset mid-scan, then release with adder_done high.
        @(negedge clk);
        sums4 = mk4(-8, -2, -2, -100);
        ad4 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pv", int'(pv4), 0);
        chk("mid_rst_pc", int'(pc4), 0);
        chk("mid_rst_ms", int'(ms4), 0);
        chk("mid_rst_busy", int'(bz4), 0);
        chk("mid_rst_ovr", int'(ov4), 0);
        sums4 = mk4(3, 9, -4, 9);
        count_pv4(3, cnt);
        chk("mid_rst_no_pv", cnt, 0);
        rst_n = 1'b1;
        wait_pv4(0, lat);
        chk("rel_lat", lat, 4);
        chk("rel_idx", int'(pc4), 1);
        chk("rel_max", int'(ms4), 9);
        @(negedge clk);
        ad4 = 1'b0;

        // Edge arriving in the DONE cycle is an overrun.
        @(negedge clk);
        sums4 = mk4(-1, 4, 4, 0);
        ad4 = 1'b1;
        @(negedge clk);
        ad4 = 1'b0;
        wait_pv4(1, lat);
        chk("done_lat", lat, 4);
        chk("done_idx", int'(pc4), 1);
        chk("done_max", int'(ms4), 4);
        chk("done_ovr_pre", int'(ov4), 0);
        ad4 = 1'b1;
        count_pv4(8, cnt);
        chk("done_no_capture", cnt, 0);
        chk("done_ovr", int'(ov4), 1);
        chk("done_idle", int'(bz4), 0);
        ad4 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/class_argmax.md
CLASS_ARGMAX -- requirements
Module: class_argmax

Interface
REQ-001 Parameter CLASS_NUM, default 10, number of classes (>=1).
REQ-002 Parameter WEIGHT_LENGTH, default 14, width of each signed class sum.
REQ-003 Parameter CLASS_IDX_W, default max(1,$clog2(CLASS_NUM)), width of class index.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 adder_done  input  1  level from the class-sum adder; high while class_sums is valid.
REQ-007 class_sums  input  signed [WEIGHT_LENGTH-1:0] x CLASS_NUM (unpacked)  per-class sums.
REQ-008 pred_class  output  CLASS_IDX_W  index of winning class.
REQ-009 max_sum  output  signed WEIGHT_LENGTH  sum of winning class.
REQ-010 pred_valid  output  1  one-cycle pulse; pred_class/max_sum valid in that cycle.
REQ-011 busy  output  1  high in SCAN and DONE states.
REQ-012 overrun  output  1  sticky; set when a new result arrives while busy.

Function
REQ-013 A new result SHALL be a rising edge of adder_done, detected against a registered copy adder_done_q.
REQ-014 FSM states SHALL be IDLE, SCAN, DONE.
REQ-015 IDLE + new result: capture all class_sums into a local array, cur_max=sums[0], cur_idx=0, cnt=1; go SCAN if CLASS_NUM>1, else DONE.
REQ-016 SCAN: each cycle compare captured sums[cnt] against cur_max with signed, strictly-greater compare; on greater, update cur_max/cur_idx; cnt++.
REQ-017 SCAN SHALL go to DONE in the cycle that compares index CLASS_NUM-1.
REQ-018 DONE: drive pred_valid=1 for exactly one cycle and return to IDLE.
REQ-019 pred_class and max_sum SHALL update on entering DONE and hold until the next DONE.
REQ-020 Latency: edge sampled at clock T gives pred_valid high in the cycle after clock T+CLASS_NUM-1, i.e. CLASS_NUM cycles after capture.
REQ-021 Ties SHALL resolve to the lowest index.
REQ-022 Changes on class_sums after capture SHALL NOT affect the result.
REQ-023 A rising edge seen in SCAN or DONE SHALL be dropped and set overrun.
REQ-024 overrun SHALL clear only on reset.
REQ-025 adder_done held high SHALL NOT retrigger; a re-trigger needs a low then high.
REQ-026 A rising edge in the same cycle as DONE->IDLE SHALL count as overrun, not a capture.

Reset
REQ-027 rst_n low SHALL force IDLE, adder_done_q=0, pred_class=0, max_sum=0, pred_valid=0, busy=0, overrun=0, cnt=0.
REQ-028 Reset mid-SCAN SHALL abort the scan with no pred_valid.
REQ-029 adder_done already high at reset release SHALL be treated as a new result, because adder_done_q resets to 0.

Structure
REQ-030 The FSM state enum typedef SHALL live in the shared project package.
REQ-031 The compare and index loop SHALL be implemented inline; no sub-module.

Verification (CLASS_NUM=4, WEIGHT_LENGTH=8)
REQ-032 Basic: sums {5,-3,12,7}, raise adder_done -> pred_valid 4 cycles after capture, pred_class=2, max_sum=12.
REQ-033 Signed/tie: sums {-8,-2,-2,-100} -> pred_class=1, max_sum=-2; all {0,0,0,0} -> pred_class=0.
REQ-034 Overrun: drop and re-raise adder_done 2 cycles after capture -> first result still given, no second pred_valid, overrun=1.
REQ-035 Hold/stability: change class_sums to {99,0,0,0} during SCAN with adder_done held -> result unchanged, single pred_valid.
REQ-036 Reset: assert rst_n low mid-SCAN -> no pred_valid, outputs 0; release with adder_done high -> new scan, result after 4 cycles.
REQ-037 CLASS_NUM=1: sums {-5} -> pred_valid 1 cycle after capture, pred_class=0, max_sum=-5.
